// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two requesters.
// Optional ALU_ARB_ZERO_FLAG_EN adds a registered rsp_zero flag captured alongside rsp_y.
module alu_arbiter #(
    parameter int WIDTH       = 4,
    parameter int OPW         = 3,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [OPW-1:0]   req_op0,
    input  logic [OPW-1:0]   req_op1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_s,
    input  logic [WIDTH-1:0] alu_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_id
`ifdef ALU_ARB_ZERO_FLAG_EN
    ,
    output logic             rsp_zero
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic       prio;
    logic [1:0] grant;
    logic       accept;
    logic       winner;

    // prio names the requester favoured when both are asking at once
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = (state == IDLE) ? grant : 2'b00;
    assign accept    = |req_ready;
    assign winner    = req_ready[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands stay on the ALU after an operation; only reset clears them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            rsp_id    <= 1'b0;
            rsp_y     <= '0;
            rsp_valid <= 1'b0;
            cnt       <= 4'd0;
            prio      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a  <= winner ? req_a1  : req_a0;
                        alu_b  <= winner ? req_b1  : req_b0;
                        alu_s  <= winner ? req_op1 : req_op0;
                        rsp_id <= winner;
                        cnt    <= CNT_INIT;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        rsp_y     <= alu_y;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        prio      <= ~rsp_id;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ARB_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_zero <= 1'b0;
        end else if (state == EXEC && cnt == 4'd0) begin
            rsp_zero <= (alu_y == '0);
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: two instances (EXEC_CYCLES 1 and 4) checked
// against a transaction-level reference model; honours ALU_ARB_ZERO_FLAG_EN.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [3:0] a0, b0, a1, b1;
    logic [2:0] op0, op1;
    logic       rsp_ready;
    logic       sel;

    logic [1:0] rr1, rr4, rv_in1, rv_in4;
    logic [3:0] aa1, ab1, ay1, ry1, aa4, ab4, ay4, ry4;
    logic [2:0] as1, as4;
    logic       rv1, rid1, rv4, rid4;
`ifdef ALU_ARB_ZERO_FLAG_EN
    logic       rz1, rz4;
`endif

    always #5 clk = ~clk;

    assign rv_in1 = sel ? 2'b00 : req_valid;
    assign rv_in4 = sel ? req_valid : 2'b00;
    assign ay1    = aa1 + ab1;
    assign ay4    = aa4 + ab4;

    alu_arbiter #(.WIDTH(4), .OPW(3), .EXEC_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv_in1), .req_ready(rr1),
        .req_a0(a0), .req_b0(b0), .req_a1(a1), .req_b1(b1),
        .req_op0(op0), .req_op1(op1),
        .alu_a(aa1), .alu_b(ab1), .alu_s(as1), .alu_y(ay1),
        .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_y(ry1), .rsp_id(rid1)
`ifdef ALU_ARB_ZERO_FLAG_EN
        , .rsp_zero(rz1)
`endif
    );

    alu_arbiter #(.WIDTH(4), .OPW(3), .EXEC_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv_in4), .req_ready(rr4),
        .req_a0(a0), .req_b0(b0), .req_a1(a1), .req_b1(b1),
        .req_op0(op0), .req_op1(op1),
        .alu_a(aa4), .alu_b(ab4), .alu_s(as4), .alu_y(ay4),
        .rsp_valid(rv4), .rsp_ready(rsp_ready), .rsp_y(ry4), .rsp_id(rid4)
`ifdef ALU_ARB_ZERO_FLAG_EN
        , .rsp_zero(rz4)
`endif
    );

    logic [1:0] cur_rr;
    logic [3:0] cur_aa, cur_ab, cur_ry;
    logic [2:0] cur_as;
    logic       cur_rv, cur_rid;
    assign cur_rr  = sel ? rr4  : rr1;
    assign cur_aa  = sel ? aa4  : aa1;
    assign cur_ab  = sel ? ab4  : ab1;
    assign cur_as  = sel ? as4  : as1;
    assign cur_rv  = sel ? rv4  : rv1;
    assign cur_ry  = sel ? ry4  : ry1;
    assign cur_rid = sel ? rid4 : rid1;
`ifdef ALU_ARB_ZERO_FLAG_EN
    logic cur_rz;
    assign cur_rz = sel ? rz4 : rz1;
`endif

    int checks = 0;
    int errors = 0;

    // Transaction-level reference model state
    int         edge_cnt;
    bit         busy;
    int         acc_edge;
    logic       prio_m;
    logic [3:0] last_a, last_b, cur_y, held_y;
    logic [2:0] last_s;
    logic       last_id, held_z;
    logic [1:0] acc_flag;

    typedef struct {
        logic       id;
        logic [3:0] y;
    } rsp_t;
    rsp_t rsp_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        busy     = 1'b0;
        acc_edge = 0;
        prio_m   = 1'b0;
        last_a   = 4'd0;
        last_b   = 4'd0;
        last_s   = 3'd0;
        last_id  = 1'b0;
        cur_y    = 4'd0;
        held_y   = 4'd0;
        held_z   = 1'b0;
        acc_flag = 2'b00;
    endtask

    // One clock cycle: compare outputs with the model, update it, advance to next negedge
    task automatic step();
        logic [1:0] exp_rr;
        bit         exp_v;
        logic [3:0] exp_y;
        logic       g;
        int         exec_e;
        exec_e = sel ? 4 : 1;
        #1;
        exp_rr = 2'b00;
        if (!busy) begin
            if (req_valid == 2'b11)      exp_rr = prio_m ? 2'b10 : 2'b01;
            else                         exp_rr = req_valid;
        end
        exp_v = busy && (edge_cnt >= acc_edge + exec_e);
        exp_y = exp_v ? cur_y : held_y;
        checkOutput("req_ready", 32'(cur_rr), 32'(exp_rr));
        checkOutput("rsp_valid", 32'(cur_rv), 32'(exp_v));
        checkOutput("rsp_y",     32'(cur_ry), 32'(exp_y));
        checkOutput("rsp_id",    32'(cur_rid), 32'(last_id));
        checkOutput("alu_a",     32'(cur_aa), 32'(last_a));
        checkOutput("alu_b",     32'(cur_ab), 32'(last_b));
        checkOutput("alu_s",     32'(cur_as), 32'(last_s));
`ifdef ALU_ARB_ZERO_FLAG_EN
        checkOutput("rsp_zero", 32'(cur_rz), 32'(exp_v ? (cur_y == 4'd0) : held_z));
`endif
        acc_flag = 2'b00;
        if (!busy && exp_rr != 2'b00) begin
            g        = exp_rr[1];
            last_a   = g ? a1 : a0;
            last_b   = g ? b1 : b0;
            last_s   = g ? op1 : op0;
            last_id  = g;
            cur_y    = 4'((int'(last_a) + int'(last_b)) % 16);
            busy     = 1'b1;
            acc_edge = edge_cnt + 1;
            acc_flag = exp_rr;
        end else if (exp_v && rsp_ready) begin
            busy   = 1'b0;
            prio_m = ~last_id;
            held_y = cur_y;
            held_z = (cur_y == 4'd0);
            rsp_q.push_back('{id: last_id, y: cur_y});
        end
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
    endtask

    // Random requesters that hold their request until accepted
    task automatic applyStimulus(input int p_req, input int p_rdy);
        for (int i = 0; i < 2; i++) begin
            if (!req_valid[i] || acc_flag[i]) begin
                req_valid[i] = ($urandom_range(99) < p_req);
                if (i == 0) begin
                    a0 = 4'($urandom_range(15)); b0 = 4'($urandom_range(15)); op0 = 3'($urandom_range(7));
                end else begin
                    a1 = 4'($urandom_range(15)); b1 = 4'($urandom_range(15)); op1 = 3'($urandom_range(7));
                end
            end
        end
        rsp_ready = ($urandom_range(99) < p_rdy);
    endtask

    task automatic pulseReset();
        req_valid = 2'b00;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_rsp_valid", 32'(cur_rv), 32'd0);
        checkOutput("rst_rsp_y",     32'(cur_ry), 32'd0);
        checkOutput("rst_rsp_id",    32'(cur_rid), 32'd0);
        checkOutput("rst_alu",       {20'd0, cur_aa, cur_ab, 1'b0, cur_as}, 32'd0);
        checkOutput("rst_req_ready", 32'(cur_rr), 32'd0);
        resetModel();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sel = 1'b0; rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = '0; op1 = '0;
        edge_cnt = 0;
        resetModel();
        #12;
        @(negedge clk);
        pulseReset();
        step();
        step();

        // Single request from requester 0
        req_valid = 2'b01; a0 = 4'd3; b0 = 4'd1; op0 = 3'd2;
        step();
        req_valid = 2'b00;
        step();
        checkOutput("single_valid", 32'(cur_rv), 32'd1);
        checkOutput("single_y",     32'(cur_ry), 32'd4);
        checkOutput("single_id",    32'(cur_rid), 32'd0);
        checkOutput("single_s",     32'(cur_as), 32'd2);
        rsp_ready = 1'b1;
        step();
        step();

        // Contention: both continuously valid, grants must alternate from requester 0
        pulseReset();
        rsp_q.delete();
        req_valid = 2'b11; a0 = 4'd1; b0 = 4'd1; a1 = 4'd7; b1 = 4'd9; op0 = 3'd0; op1 = 3'd0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 14; i++) step();
        checkOutput("cont_count", 32'(rsp_q.size() >= 4), 32'd1);
        if (rsp_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput("cont_id", 32'(rsp_q[i].id), 32'(i % 2));
                checkOutput("cont_y",  32'(rsp_q[i].y),  (i % 2 == 0) ? 32'd2 : 32'd0);
            end
        end

        // Response backpressure with requester 1 waiting
        pulseReset();
        req_valid = 2'b01; a0 = 4'd5; b0 = 4'd6; op0 = 3'd1; rsp_ready = 1'b0;
        step();
        req_valid = 2'b11; a1 = 4'd2; b1 = 4'd2; op1 = 3'd4;
        step();
        for (int i = 0; i < 5; i++) step();
        checkOutput("bp_y",  32'(cur_ry), 32'd11);
        checkOutput("bp_rr", 32'(cur_rr), 32'd0);
        rsp_ready = 1'b1;
        step();
        req_valid = 2'b10;
        #1;
        checkOutput("bp_resume", 32'(cur_rr), 32'd2);
        step();

        for (int i = 0; i < 300; i++) begin
            applyStimulus(60, 60);
            step();
        end

        // EXEC_CYCLES=4 instance: latency and hold
        sel = 1'b1;
        pulseReset();
        rsp_ready = 1'b0;
        req_valid = 2'b01; a0 = 4'd9; b0 = 4'd8; op0 = 3'd5;
        step();
        req_valid = 2'b00;
        for (int i = 0; i < 3; i++) step();
        checkOutput("lat_not_yet", 32'(cur_rv), 32'd0);
        step();
        checkOutput("lat_valid", 32'(cur_rv), 32'd1);
        checkOutput("lat_y",     32'(cur_ry), 32'd1);
        rsp_ready = 1'b1;
        step();

        // Reset during EXEC: operation lost, next request served from prio 0
        req_valid = 2'b10; a1 = 4'd4; b1 = 4'd4; op1 = 3'd3; rsp_ready = 1'b1;
        step();
        req_valid = 2'b00;
        step();
        step();
        pulseReset();
        req_valid = 2'b11;
        step();
        checkOutput("post_rst_grant", 32'(last_id), 32'd0);
        for (int i = 0; i < 400; i++) begin
            applyStimulus(60, 50);
            step();
        end

        // Reset while a response is pending
        req_valid = 2'b00; rsp_ready = 1'b0;
        for (int i = 0; i < 20 && !busy; i++) begin
            req_valid = 2'b01;
            step();
        end
        req_valid = 2'b00;
        for (int i = 0; i < 20 && !cur_rv; i++) step();
        checkOutput("wait_rsp", 32'(cur_rv), 32'd1);
        pulseReset();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
